// File: rtl/toggle_pkg.sv
// Shared types and helpers for the toggle debounce generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package toggle_pkg;

    // Debounce / repeat FSM states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS_CHK = 3'd1,
        HELD      = 3'd2,
        REPEAT    = 3'd3,
        REL_CHK   = 3'd4
    } tdg_state_t;

    // Largest of three values; sizes the shared down-counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous level.
// Latency: STAGES clk edges from d to q.
// Backpressure: none; free-running sampler.
//
// Ports: clk - sampling clock; rst - async active-low reset (chain clears to 0);
//        d - asynchronous input level; q - synchronised level.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/toggle_debounce_gen.sv
// Button conditioner: synchronise, debounce, emit one T strobe per press (+ optional auto-repeat).
// Latency: press/release seen SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges after the raw edge.
// Backpressure: none; strobes are fire-and-forget single-cycle pulses.
//
// Ports: clk - system clock; rst - async active-low reset;
//        btn_in - raw button level (1 = pressed);
//        t_pulse - one-cycle toggle strobe; btn_level - debounced level; busy - FSM not IDLE.
module toggle_debounce_gen
    import toggle_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic t_pulse,
    output logic btn_level,
    output logic busy
);

    localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);

    // Reload values: the counter expires on the cycle it reads zero, so load N-1.
    localparam logic [CW-1:0] LD_DEB = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LD_DLY = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] LD_PER = CW'(REPEAT_PERIOD - 1);

    logic          btn_s;
    logic          run_q;
    tdg_state_t    state_q;
    logic [CW-1:0] cnt_q;
    logic          t_pulse_q;
    logic          btn_level_q;
    logic          busy_q;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_btn_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_s)
    );

    // Reset release is registered once so the FSM holds IDLE on the first edge
    // after rst rises; the earliest state change is the second edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Button change is always checked before counter expiry in each state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            t_pulse_q   <= 1'b0;
            btn_level_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            t_pulse_q <= 1'b0;
            if (run_q) begin
                case (state_q)
                    IDLE: begin
                        if (btn_s) begin
                            state_q <= PRESS_CHK;
                            cnt_q   <= LD_DEB;
                            busy_q  <= 1'b1;
                        end
                    end

                    PRESS_CHK: begin
                        if (!btn_s) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end else if (cnt_q == '0) begin
                            state_q     <= HELD;
                            cnt_q       <= LD_DLY;
                            t_pulse_q   <= 1'b1;
                            btn_level_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end

                    HELD: begin
                        if (!btn_s) begin
                            state_q <= REL_CHK;
                            cnt_q   <= LD_DEB;
                        end else if ((REPEAT_EN != 0) && (cnt_q == '0)) begin
                            state_q   <= REPEAT;
                            cnt_q     <= LD_PER;
                            // Guard keeps strobes one cycle wide even with a 1-cycle delay.
                            t_pulse_q <= ~t_pulse_q;
                        end else if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end

                    REPEAT: begin
                        if (!btn_s) begin
                            state_q <= REL_CHK;
                            cnt_q   <= LD_DEB;
                        end else if (cnt_q == '0) begin
                            cnt_q     <= LD_PER;
                            t_pulse_q <= ~t_pulse_q;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end

                    REL_CHK: begin
                        if (btn_s) begin
                            // Bounce on release: back to HELD, repeat delay starts over.
                            state_q <= HELD;
                            cnt_q   <= LD_DLY;
                        end else if (cnt_q == '0) begin
                            state_q     <= IDLE;
                            cnt_q       <= '0;
                            btn_level_q <= 1'b0;
                            busy_q      <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end

                    default: begin
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        btn_level_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign t_pulse   = t_pulse_q;
    assign btn_level = btn_level_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_toggle_debounce_gen.sv
// Directed bench for toggle_debounce_gen: press, bounce, release bounce, auto-repeat,
// reset mid-hold and a downstream T flip-flop.
// Latency/backpressure: n/a.
module tb_toggle_debounce_gen;

    logic clk;
    logic rst;
    logic btn0, btn1;
    logic t_pulse0, btn_level0, busy0;
    logic t_pulse1, btn_level1, busy1;
    logic tff_q;

    int n_cmp;
    int n_bad;

    // dut0: no auto-repeat; dut1: auto-repeat enabled.
    toggle_debounce_gen #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (0),
        .REPEAT_DELAY    (64),
        .REPEAT_PERIOD   (32)
    ) dut0 (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn0),
        .t_pulse   (t_pulse0),
        .btn_level (btn_level0),
        .busy      (busy0)
    );

    toggle_debounce_gen #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (1),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn1),
        .t_pulse   (t_pulse1),
        .btn_level (btn_level1),
        .busy      (busy1)
    );

    // Downstream T flip-flop fed by dut0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tff_q <= 1'b0;
        else if (t_pulse0) tff_q <= ~tff_q;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        btn0 = 1'b0;
        btn1 = 1'b0;
        step();
        step();
        n_cmp++; if (t_pulse0 !== 1'b0)   begin n_bad++; $display("FAIL reset_t_pulse0 got %b want 0", t_pulse0); end
        n_cmp++; if (btn_level0 !== 1'b0) begin n_bad++; $display("FAIL reset_level0 got %b want 0", btn_level0); end
        n_cmp++; if (busy0 !== 1'b0)      begin n_bad++; $display("FAIL reset_busy0 got %b want 0", busy0); end
        n_cmp++; if (t_pulse1 !== 1'b0)   begin n_bad++; $display("FAIL reset_t_pulse1 got %b want 0", t_pulse1); end
        n_cmp++; if (btn_level1 !== 1'b0) begin n_bad++; $display("FAIL reset_level1 got %b want 0", btn_level1); end
        n_cmp++; if (busy1 !== 1'b0)      begin n_bad++; $display("FAIL reset_busy1 got %b want 0", busy1); end
        rst = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            n_cmp++; if (busy0 !== 1'b0 || t_pulse0 !== 1'b0) begin
                n_bad++; $display("FAIL reset_idle edge %0d busy=%b pulse=%b want 0/0", i, busy0, t_pulse0);
            end
        end
    endtask

    task automatic test_clean_press();
        btn0 = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step();
            n_cmp++; if (t_pulse0 !== (i == 7)) begin
                n_bad++; $display("FAIL press_pulse edge %0d got %b want %b", i, t_pulse0, (i == 7));
            end
            n_cmp++; if (btn_level0 !== (i >= 7)) begin
                n_bad++; $display("FAIL press_level edge %0d got %b want %b", i, btn_level0, (i >= 7));
            end
            n_cmp++; if (busy0 !== (i >= 3)) begin
                n_bad++; $display("FAIL press_busy edge %0d got %b want %b", i, busy0, (i >= 3));
            end
        end
        btn0 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            n_cmp++; if (btn_level0 !== (i < 7)) begin
                n_bad++; $display("FAIL release_level edge %0d got %b want %b", i, btn_level0, (i < 7));
            end
            n_cmp++; if (busy0 !== (i < 7)) begin
                n_bad++; $display("FAIL release_busy edge %0d got %b want %b", i, busy0, (i < 7));
            end
            n_cmp++; if (t_pulse0 !== 1'b0) begin
                n_bad++; $display("FAIL release_pulse edge %0d got %b want 0", i, t_pulse0);
            end
        end
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 20; k++) begin
            btn0 = ((k / 2) % 2 == 0);
            step();
            n_cmp++; if (t_pulse0 !== 1'b0 || btn_level0 !== 1'b0) begin
                n_bad++; $display("FAIL bounce cycle %0d pulse=%b level=%b want 0/0", k, t_pulse0, btn_level0);
            end
        end
        btn0 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            n_cmp++; if (t_pulse0 !== 1'b0 || btn_level0 !== 1'b0) begin
                n_bad++; $display("FAIL bounce_tail cycle %0d pulse=%b level=%b want 0/0", k, t_pulse0, btn_level0);
            end
        end
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL bounce_idle busy got %b want 0", busy0); end
    endtask

    task automatic test_release_bounce();
        btn0 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            n_cmp++; if (t_pulse0 !== (i == 7)) begin
                n_bad++; $display("FAIL relb_press edge %0d got %b want %b", i, t_pulse0, (i == 7));
            end
        end
        // 3 low, 3 high, then a clean low.
        for (int k = 0; k < 6; k++) begin
            btn0 = (k >= 3);
            step();
            n_cmp++; if (t_pulse0 !== 1'b0 || btn_level0 !== 1'b1) begin
                n_bad++; $display("FAIL relb_bounce cycle %0d pulse=%b level=%b want 0/1", k, t_pulse0, btn_level0);
            end
        end
        btn0 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            n_cmp++; if (btn_level0 !== (i < 7) || t_pulse0 !== 1'b0) begin
                n_bad++; $display("FAIL relb_fall edge %0d level=%b pulse=%b want %b/0", i, btn_level0, t_pulse0, (i < 7));
            end
        end
    endtask

    task automatic test_auto_repeat();
        logic exp_p;
        btn1 = 1'b1;
        for (int i = 1; i <= 90; i++) begin
            step();
            exp_p = (i == 7) || (i == 27) || (i == 35) || (i == 43) || (i == 51) || (i == 59);
            n_cmp++; if (t_pulse1 !== exp_p) begin
                n_bad++; $display("FAIL repeat_pulse edge %0d got %b want %b", i, t_pulse1, exp_p);
            end
            n_cmp++; if (btn_level1 !== (i >= 7 && i < 69)) begin
                n_bad++; $display("FAIL repeat_level edge %0d got %b want %b", i, btn_level1, (i >= 7 && i < 69));
            end
            n_cmp++; if (busy1 !== (i >= 3 && i < 69)) begin
                n_bad++; $display("FAIL repeat_busy edge %0d got %b want %b", i, busy1, (i >= 3 && i < 69));
            end
            if (i == 62) btn1 = 1'b0;
        end
    endtask

    task automatic test_reset_mid_held();
        btn0 = 1'b1;
        for (int i = 1; i <= 12; i++) step();
        n_cmp++; if (btn_level0 !== 1'b1 || busy0 !== 1'b1) begin
            n_bad++; $display("FAIL rst_pre level=%b busy=%b want 1/1", btn_level0, busy0);
        end
        rst = 1'b0;
        #1;
        n_cmp++; if (btn_level0 !== 1'b0 || busy0 !== 1'b0 || t_pulse0 !== 1'b0) begin
            n_bad++; $display("FAIL rst_immediate level=%b busy=%b pulse=%b want 0/0/0", btn_level0, busy0, t_pulse0);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (btn_level0 !== 1'b0 || busy0 !== 1'b0 || t_pulse0 !== 1'b0) begin
                n_bad++; $display("FAIL rst_hold cycle %0d level=%b busy=%b pulse=%b want 0/0/0", k, btn_level0, busy0, t_pulse0);
            end
        end
        rst = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            n_cmp++; if (t_pulse0 !== (i == 7) || btn_level0 !== (i >= 7)) begin
                n_bad++; $display("FAIL rst_repress edge %0d pulse=%b level=%b want %b/%b", i, t_pulse0, btn_level0, (i == 7), (i >= 7));
            end
        end
        btn0 = 1'b0;
        for (int i = 1; i <= 10; i++) step();
        n_cmp++; if (btn_level0 !== 1'b0 || busy0 !== 1'b0) begin
            n_bad++; $display("FAIL rst_release level=%b busy=%b want 0/0", btn_level0, busy0);
        end
    endtask

    task automatic test_downstream();
        logic prev;
        int   flips;
        logic exp_q;
        rst  = 1'b0;
        btn0 = 1'b0;
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        n_cmp++; if (tff_q !== 1'b0) begin n_bad++; $display("FAIL tff_init got %b want 0", tff_q); end
        exp_q = 1'b0;
        for (int p = 0; p < 3; p++) begin
            flips = 0;
            prev  = tff_q;
            for (int k = 0; k < 24; k++) begin
                btn0 = (k < 12);
                step();
                if (tff_q !== prev) flips++;
                prev = tff_q;
            end
            exp_q = ~exp_q;
            n_cmp++; if (tff_q !== exp_q) begin
                n_bad++; $display("FAIL tff_q press %0d got %b want %b", p, tff_q, exp_q);
            end
            n_cmp++; if (flips != 1) begin
                n_bad++; $display("FAIL tff_edges press %0d got %0d want 1", p, flips);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_auto_repeat();
        test_reset_mid_held();
        test_downstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
